systolic_edge_feeder: RTL
=========================

# systolic_edge_feeder

Drives one edge (west `in_a` lanes or north `in_b` lanes) of the processing-element array. It accepts one LANES-wide operand vector per cycle from the tile buffer, applies the diagonal skew the systolic array needs (lane i delayed i cycles), and zero-fills idle cycles. It also generates the per-lane done pulse that the PEs sample to fold their two partial sums into the final answer.

## Interface
- `WIDTH`, 16: bits per operand (FP16 by default; the feeder never interprets data).
- `LANES`, 4: number of edge lanes (array rows or columns); ≥ 2.
- `DONE_DELAY`, 2: cycles between a lane's last element and its done pulse; set equal to PE multiplier `PIPE_STAGE`; ≥ 0.

Ports (clock and reset first):
- `clk`  in  1  clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream vector valid.
- `in_ready`  out  1  feeder can accept a vector this cycle.
- `in_data`  in  LANES*WIDTH  operand vector; lane i = bits [i*WIDTH +: WIDTH].
- `in_last`  in  1  qualifies `in_valid`; marks the final vector of the tile.
- `out_data`  out  LANES*WIDTH  skewed operands to the array edge, same lane packing.
- `out_done`  out  LANES  per-lane done pulse to that lane's edge PE `in_done_flag`.
- `busy`  out  1  high in STREAM or DRAIN.
- `tile_done`  out  1  one-cycle pulse when a tile has fully drained.

## Operation
- Accept occurs on cycle edges where `in_valid && in_ready`.
- Lane i has a shift line of i+1 registers. On every cycle, each line shifts. Its input is lane i of `in_data` on an accept, and 0 otherwise (bubble becomes zero, which adds nothing to the accumulation).
- Each line also carries a 1-bit last tag (`in_last && accept`). A tag emerging from lane i enters a DONE_DELAY-stage delay, whose output is `out_done[i]`.
- State machine:
  - IDLE: `in_ready`=1, `busy`=0. An accept with `in_last`=0 goes to STREAM. An accept with `in_last`=1 goes straight to DRAIN (single-vector tile).
  - STREAM: `in_ready`=1, `busy`=1. A cycle without valid inserts a zero bubble and stays in STREAM. An accept with `in_last`=1 goes to DRAIN.
  - DRAIN: `in_ready`=0, `busy`=1. The counter loads LANES-1+DONE_DELAY on entry and decrements each cycle. At 0 the block pulses `tile_done` and goes to IDLE, in the same cycle that `out_done[LANES-1]` is high.
- `in_last` without `in_valid` is ignored. `in_valid` during DRAIN is not accepted; upstream must hold it.
- Reset:
  - All shift lines, tag lines and done delays clear.
  - `out_data`=0, `out_done`=0, `busy`=0, `tile_done`=0.
  - State goes to IDLE, `in_ready`=1 in the first cycle after reset.
  - Reset mid-tile discards everything in flight; no done pulse is produced for the aborted tile.

## Timing
- The vector accepted at edge t drives lane i of `out_data` during cycle t+1+i, for exactly one cycle.
- Last vector accepted at edge t_L:
  - `out_done[i]` is high only in cycle t_L+1+i+DONE_DELAY.
  - `tile_done` is high only in cycle t_L+LANES+DONE_DELAY.
  - `in_ready` is low in cycles t_L+1 through t_L+LANES+DONE_DELAY.
  - `in_ready` is high again from cycle t_L+LANES+DONE_DELAY+1.
- Throughput is one vector per cycle in STREAM. Tile-to-tile gap is LANES+DONE_DELAY cycles.
- `out_data` and `out_done` are registered, with no combinational path from inputs. `in_ready` is a function of state only.

## Test plan
Defaults for all scenarios: LANES=4, WIDTH=16, DONE_DELAY=2.
- **Skew check:** reset, then accept vectors V0..V3 (lane i of Vk = 16'h1000+16*k+i, `in_last` on V3) at edges 0..3.
  - Lane 2 shows 0, 0, then 16'h1002, 16'h1012, 16'h1022, 16'h1032 at cycles 3..6, then 0.
  - `out_done` = 4'b0001, 4'b0010, 4'b0100, 4'b1000 at cycles 6, 7, 8, 9.
  - `tile_done` at cycle 9; `in_ready` high at cycle 10.
- **Bubble:** valid low for one cycle between V1 and V2. Each lane carries one zero between its V1 and V2 elements, and all done pulses shift one cycle later.
- **Single-vector tile:** accept with `in_valid`=`in_last`=1 from IDLE at edge 0.
  - `busy` goes high at cycle 1.
  - `out_done[0]` high at cycle 3, `out_done[3]` at cycle 6, `tile_done` at cycle 6.
- **Backpressure in DRAIN:** hold `in_valid`=1 with a new tile through DRAIN. No accept occurs until `in_ready` returns, and the first element of the new tile appears on lane 0 the cycle after that accept.
- **Reset mid-tile:** assert `reset` for one cycle two cycles after the last accept.
  - All outputs are 0 next cycle, `out_done` never pulses, `in_ready`=1.
- **Back-to-back tiles:** two 8-vector tiles separated only by the mandatory gap. Per-lane data order is preserved, and exactly one `out_done` pulse per lane per tile.

Source files
------------

// File: rtl/systolic_edge_feeder.sv
// systolic_edge_feeder
//   Feeds one edge (west A lanes or north B lanes) of the PE array. Takes one
//   LANES-wide operand vector per cycle from the tile buffer and skews it
//   diagonally so that lane i lags by i cycles. Cycles with no vector accepted
//   become zero operands, which add nothing to the accumulation. The final
//   vector of a tile carries a tag down each lane. After a further DONE_DELAY
//   cycles the tag raises that lane's done pulse, which the edge PE uses to
//   fold its partial sums.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset; discards everything in flight
//   in_valid_i   upstream vector valid
//   in_ready_o   feeder can accept a vector this cycle (depends on state only)
//   in_data_i    operand vector, lane i = [i*WIDTH +: WIDTH]
//   in_last_i    marks the final vector of a tile (qualified by in_valid_i)
//   out_data_o   skewed operands to the array edge, same lane packing
//   out_done_o   per-lane done pulse to each edge PE
//   busy_o       high while a tile is streaming or draining
//   tile_done_o  one-cycle pulse when the tile has fully drained
module systolic_edge_feeder #(
  parameter int WIDTH      = 16,
  parameter int LANES      = 4,
  parameter int DONE_DELAY = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [LANES*WIDTH-1:0] in_data_i,
  input  logic                   in_last_i,
  output logic [LANES*WIDTH-1:0] out_data_o,
  output logic [LANES-1:0]       out_done_o,
  output logic                   busy_o,
  output logic                   tile_done_o
);

  // DRAIN lasts until the last lane's done pulse. That pulse comes
  // LANES+DONE_DELAY cycles after the last accept.
  localparam int DRAIN_LEN = LANES + DONE_DELAY;
  localparam int CNT_W     = $clog2(DRAIN_LEN);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } feederState_t;

  feederState_t state_q, state_d;
  logic [CNT_W-1:0] drainCnt_q, drainCnt_d;
  logic accept;
  logic lastTag;

  assign accept  = in_valid_i && in_ready_o;
  assign lastTag = accept && in_last_i;

  // State register and drain counter. Reset returns to IDLE so the feeder is
  // ready in the very next cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      drainCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  // Next-state logic and state-derived outputs. in_ready_o depends only on
  // the state, so upstream never sees a combinational loop through valid.
  // tile_done_o fires on the last DRAIN cycle. This lines up with the done
  // pulse of the last lane.
  always_comb begin
    state_d     = state_q;
    drainCnt_d  = drainCnt_q;
    in_ready_o  = 1'b1;
    busy_o      = 1'b0;
    tile_done_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_last_i) begin
            state_d    = DRAIN;
            drainCnt_d = DRAIN_LOAD;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        busy_o = 1'b1;
        if (accept && in_last_i) begin
          state_d    = DRAIN;
          drainCnt_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        in_ready_o = 1'b0;
        busy_o     = 1'b1;
        if (drainCnt_q == '0) begin
          tile_done_o = 1'b1;
          state_d     = IDLE;
        end else begin
          drainCnt_d = drainCnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Each lane has its own data and tag delay lines.
  // Data: lane i has i+1 registers, which gives the diagonal skew.
  // Tag: the last-tag line and the done delay are merged into one shift
  // register of i+1+DONE_DELAY stages. Because of this, a DONE_DELAY of zero
  // needs no special case.
  for (genvar g = 0; g < LANES; g++) begin : gLane
    localparam int DATA_DEPTH = g + 1;
    localparam int TAG_DEPTH  = g + 1 + DONE_DELAY;

    logic [WIDTH-1:0]     dataLine_q [DATA_DEPTH];
    logic [TAG_DEPTH-1:0] tagLine_q;

    // Shift every cycle. Cycles with no accept push a zero operand and a
    // cleared tag.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int k = 0; k < DATA_DEPTH; k++) begin
          dataLine_q[k] <= '0;
        end
        tagLine_q <= '0;
      end else begin
        dataLine_q[0] <= accept ? in_data_i[g*WIDTH +: WIDTH] : '0;
        for (int k = 1; k < DATA_DEPTH; k++) begin
          dataLine_q[k] <= dataLine_q[k-1];
        end
        tagLine_q[0] <= lastTag;
        for (int k = 1; k < TAG_DEPTH; k++) begin
          tagLine_q[k] <= tagLine_q[k-1];
        end
      end
    end

    assign out_data_o[g*WIDTH +: WIDTH] = dataLine_q[DATA_DEPTH-1];
    assign out_done_o[g]                = tagLine_q[TAG_DEPTH-1];
  end

endmodule
